// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer: an internal prescaler produces a one-cycle tick
// every DIV clocks while running, and each tick decrements out until it reaches 0.
module cnt_down_timer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 500,
  parameter int PW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PW-1:0]    DIV_M1 = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t        state;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      out   <= '0;
      presc <= '0;
      tick  <= 1'b0;
    end else if (load) begin
      out   <= load_val;
      presc <= '0;
      state <= IDLE;
      tick  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick  <= 1'b0;
          presc <= '0;
          // A zero count skips RUN entirely so no tick is ever emitted.
          if (start) state <= (out != '0) ? RUN : DONE;
        end
        RUN: begin
          if (pause) begin
            tick <= 1'b0;
          end else if (presc == DIV_M1) begin
            presc <= '0;
            tick  <= 1'b1;
            out   <= out - ONE;
            if (out == ONE) state <= DONE;
          end else begin
            presc <= presc + 1'b1;
            tick  <= 1'b0;
          end
        end
        DONE: begin
          tick <= 1'b0;
        end
        default: begin
          state <= IDLE;
          tick  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cnt_down_timer.sv
// Scoreboard bench for cnt_down_timer: a run-cycle reference model predicts every
// clock's outputs into a queue that an independent monitor drains and compares.
module tb_cnt_down_timer;

  localparam int W = 4;
  localparam int D = 4;
  localparam int P = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, load, start, pause;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         tick, busy, done;

  cnt_down_timer #(.WIDTH(W), .DIV(D), .PW(P)) u_dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .out(out), .tick(tick), .busy(busy), .done(done)
  );

  // Second instance at default parameters for the long 15 x 500 run.
  logic       d_rst, d_load, d_start, d_pause;
  logic [3:0] d_val, d_out;
  logic       d_tick, d_busy, d_done;

  cnt_down_timer u_def (
    .clk(clk), .rst(d_rst), .load(d_load), .load_val(d_val), .start(d_start),
    .pause(d_pause), .out(d_out), .tick(d_tick), .busy(d_busy), .done(d_done)
  );

  typedef struct packed {
    logic [W-1:0] out;
    logic         tick;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;
  bit   def_finished = 1'b0;

  // Reference model: mode 0 idle, 1 running, 2 finished. While running the
  // count is derived from the loaded value and the number of unpaused cycles.
  int m_mode = 0;
  int m_n    = 0;
  int m_run  = 0;
  int m_out  = 0;
  int m_tick = 0;

  function automatic void check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.out  = W'(m_out);
    e.tick = (m_tick != 0);
    e.busy = (m_mode == 1);
    e.done = (m_mode == 2);
    exp_q.push_back(e);
  endfunction

  function automatic void model(input logic r, input logic l, input int lv,
                                input logic s, input logic p);
    m_tick = 0;
    if (!r) begin
      m_mode = 0; m_out = 0; m_run = 0;
    end else if (l) begin
      m_mode = 0; m_out = lv % (1 << W);
    end else if (m_mode == 0 && s) begin
      if (m_out == 0) m_mode = 2;
      else begin m_mode = 1; m_n = m_out; m_run = 0; end
    end else if (m_mode == 1 && !p) begin
      m_run++;
      if (m_run % D == 0) m_tick = 1;
      m_out = m_n - m_run / D;
      if (m_out == 0) m_mode = 2;
    end
  endfunction

  // One clock of stimulus: drive on the falling edge, predict the next rising edge.
  task automatic step(input logic r, input logic l, input int lv,
                      input logic s, input logic p);
    logic r_prev;
    @(negedge clk);
    r_prev   = rst;
    rst      = r;
    load     = l;
    load_val = W'(lv);
    start    = s;
    pause    = p;
    if (r_prev && !r) begin
      #1;
      check("async_rst_out", out, 0);
      check("async_rst_tick", tick, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_done", done, 0);
    end
    model(r, l, lv, s, p);
    push_exp();
  endtask

  task automatic cyc(input logic l, input int lv, input logic s, input logic p);
    step(1'b1, l, lv, s, p);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: every rising edge produces one expected record.
  initial begin
    exp_t e;
    while (!stim_done) begin
      @(posedge clk);
      #1;
      if (stim_done) break;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL queue_underflow: got empty queue expected a record (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("out", out, e.out);
        check("tick", tick, e.tick);
        check("busy", busy, e.busy);
        check("done", done, e.done);
      end
    end
  end

  // Main stimulus: directed scenarios followed by random traffic.
  initial begin
    logic p_lvl;
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_val = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_out", out, 0);
    check("reset_tick", tick, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    push_exp();

    idle(0);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Load 5 and run to completion.
    cyc(1'b1, 5, 1'b0, 1'b0); cyc(1'b0, 0, 1'b1, 1'b0); idle(25);
    // Load 3 with a 7-cycle pause after two prescaler cycles.
    cyc(1'b1, 3, 1'b0, 1'b0); cyc(1'b0, 0, 1'b1, 1'b0); idle(2);
    repeat (7) cyc(1'b0, 0, 1'b0, 1'b1);
    idle(15);
    // Zero-length run; start in DONE is ignored.
    cyc(1'b1, 0, 1'b0, 1'b0); cyc(1'b0, 0, 1'b1, 1'b0); idle(3);
    cyc(1'b0, 0, 1'b1, 1'b0); idle(2);
    // Load and start together mid-run: load wins, then count 2,1,0.
    cyc(1'b1, 9, 1'b0, 1'b0); cyc(1'b0, 0, 1'b1, 1'b0); idle(12);
    cyc(1'b1, 2, 1'b1, 1'b0); idle(3);
    cyc(1'b0, 0, 1'b1, 1'b0); idle(12);
    // Reset mid-run at out=7, then start with out=0 goes straight to DONE.
    cyc(1'b1, 8, 1'b0, 1'b0); cyc(1'b0, 0, 1'b1, 1'b0); idle(5);
    step(1'b0, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0); idle(3);

    p_lvl = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) == 0) p_lvl = ~p_lvl;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 69) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 5) == 0),
           p_lvl);
    end

    @(posedge clk);
    #2;
    stim_done = 1'b1;
    check("queue_drain", exp_q.size(), 0);

    for (int i = 0; i < 10000 && !def_finished; i++) @(posedge clk);
    if (!def_finished) begin
      total++; bad++;
      $display("FAIL def_timeout: got unfinished expected finished");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Default-parameter run: load 15, ticks every 500 cycles, done at cycle 7500.
  initial begin
    int n, ticks, done_at;
    d_rst = 1'b1; d_load = 1'b0; d_start = 1'b0; d_pause = 1'b0; d_val = '0;
    #2 d_rst = 1'b0;
    @(negedge clk); d_rst = 1'b1;
    @(negedge clk); d_load = 1'b1; d_val = 4'd15;
    @(negedge clk); d_load = 1'b0; d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    n = 0; ticks = 0; done_at = -1;
    while (n < 8000 && done_at < 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("def_busy", d_busy, 1);
      if (d_tick) begin
        ticks++;
        check("def_tick_time", n, ticks * 500);
        check("def_tick_out", d_out, 15 - ticks);
      end
      if (d_done) done_at = n;
    end
    check("def_done_cycle", done_at, 7500);
    check("def_tick_count", ticks, 15);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (d_tick) ticks++;
    end
    check("def_hold_out", d_out, 0);
    check("def_hold_done", d_done, 1);
    check("def_no_extra_tick", ticks, 15);
    def_finished = 1'b1;
  end

endmodule
